mem_lsu_ctrl: RTL

- Load/store control stage directly upstream of the data port of the dual-port simulation memory.
- Takes one CPU memory request at a time (byte/half/word, load or store) and drives the memory's synchronous read port or masked write port.
- Sign- or zero-extends load data and returns it with a valid/ready response handshake.
- Flags misaligned accesses.

---
 rtl/mem_lsu_ctrl_pkg.sv | 47 ++++
 rtl/mem_lsu_ext.sv | 28 ++
 rtl/mem_lsu_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_ctrl_pkg.sv
// mem_lsu_ctrl_pkg
//   Shared definitions for the load/store control stage:
//   - default address/data widths;
//   - access size encodings;
//   - FSM state encoding;
//   - length-mask constants;
//   - helper functions for the mask and for the alignment test.
//   Mask bit 0 corresponds to pMemData_pWr_bMask_3, and bit 3 to pMemData_pWr_bMask_0.
package mem_lsu_ctrl_pkg;

  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_DATA_WIDTH = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Length mask for a size code; code 3 behaves as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      default: size_mask = MASK_W;
    endcase
  endfunction

  // True when the low address bits violate the natural alignment of the size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// mem_lsu_ext
//   Purely combinational extraction and extension of load data.
//   Ports:
//     data      - raw memory read word
//     size      - access size code (byte/half/word, 3 = word)
//     signed_en - sign-extend when 1, otherwise zero-extend
//     ext_data  - right-aligned, extended result
module mem_lsu_ext
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  signed_en,
  output logic [DATA_WIDTH-1:0] ext_data
);

  always_comb begin
    ext_data = data;
    case (size)
      SZ_B: ext_data = {{(DATA_WIDTH-8){signed_en & data[7]}}, data[7:0]};
      SZ_H: ext_data = {{(DATA_WIDTH-16){signed_en & data[15]}}, data[15:0]};
      default: ext_data = data;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// mem_lsu_ctrl
//   Single-outstanding load/store controller in front of the data port of
//   the simulation memory.
//
//   Ports:
//     iClock / iReset        - clock, synchronous active-high reset
//     iReq_*                 - request channel (valid/ready handshake)
//     oResp_*                - response channel (valid/ready handshake)
//     pMemData_pRd_*         - synchronous read port (data one cycle after enable)
//     pMemData_pWr_*         - masked write port
//
//   Build option: define MEM_LSU_ALIGN_CHK_EN to answer misaligned requests
//   immediately with oResp_err instead of touching memory.
//
//   Sequence of states:
//     IDLE -> ISSUE -> CAPT -> RESP   for loads
//     IDLE -> ISSUE -> RESP           for stores
//     IDLE -> RESP                    for misaligned requests, when the check is built in
module mem_lsu_ctrl
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReq_valid,
  output logic                  oReq_ready,
  input  logic                  iReq_wr,
  input  logic [1:0]            iReq_size,
  input  logic                  iReq_signed,
  input  logic [ADDR_WIDTH-1:0] iReq_addr,
  input  logic [DATA_WIDTH-1:0] iReq_wdata,
  output logic                  oResp_valid,
  input  logic                  iResp_ready,
  output logic [DATA_WIDTH-1:0] oResp_rdata,
  output logic                  oResp_err,
  output logic                  pMemData_pRd_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
  input  logic [DATA_WIDTH-1:0] iMemData_pRd_bData,
  output logic                  pMemData_pWr_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
  output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
  output logic                  pMemData_pWr_bMask_0,
  output logic                  pMemData_pWr_bMask_1,
  output logic                  pMemData_pWr_bMask_2,
  output logic                  pMemData_pWr_bMask_3
);

  lsu_state_t            state_reg, state_next;
  logic                  wr_reg;
  logic [1:0]            size_reg;
  logic                  signed_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  err_reg;

  logic                  accept;
  logic                  misaligned_in;
  logic                  rd_en, wr_en;
  logic [3:0]            mask;
  logic [DATA_WIDTH-1:0] ext_data;

`ifdef MEM_LSU_ALIGN_CHK_EN
  assign misaligned_in = is_misaligned(iReq_size, iReq_addr[1:0]);
`else
  assign misaligned_in = 1'b0;
`endif

  assign accept = (state_reg == ST_IDLE) && iReq_valid;

  mem_lsu_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ext (
    .data      (iMemData_pRd_bData),
    .size      (size_reg),
    .signed_en (signed_reg),
    .ext_data  (ext_data)
  );

  // Next-state and handshake/enable decode.
  always_comb begin
    state_next = state_reg;
    oReq_ready = 1'b0;
    oResp_valid = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        oReq_ready = 1'b1;
        if (iReq_valid) begin
          state_next = misaligned_in ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_reg) begin
          wr_en = 1'b1;
          state_next = ST_RESP;
        end else begin
          rd_en = 1'b1;
          state_next = ST_CAPT;
        end
      end
      ST_CAPT: state_next = ST_RESP;
      ST_RESP: begin
        oResp_valid = 1'b1;
        if (iResp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero whenever the port is not enabled.
  assign mask = wr_en ? size_mask(size_reg) : 4'b0000;
  assign pMemData_pRd_bEn = rd_en;
  assign pMemData_pRd_bAddr = rd_en ? addr_reg : '0;
  assign pMemData_pWr_bEn = wr_en;
  assign pMemData_pWr_bAddr = wr_en ? addr_reg : '0;
  assign pMemData_pWr_bData = wr_en ? wdata_reg : '0;
  assign pMemData_pWr_bMask_0 = mask[3];
  assign pMemData_pWr_bMask_1 = mask[2];
  assign pMemData_pWr_bMask_2 = mask[1];
  assign pMemData_pWr_bMask_3 = mask[0];

  assign oResp_rdata = rdata_reg;
  assign oResp_err = err_reg;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_reg <= ST_IDLE;
      wr_reg <= 1'b0;
      size_reg <= 2'd0;
      signed_reg <= 1'b0;
      addr_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_reg <= iReq_wr;
        size_reg <= iReq_size;
        signed_reg <= iReq_signed;
        addr_reg <= iReq_addr;
        wdata_reg <= iReq_wdata;
        // Stores and errored requests answer with zero data, so clear it here;
        // loads overwrite it in CAPT.
        rdata_reg <= '0;
        err_reg <= misaligned_in;
      end
      if (state_reg == ST_CAPT) begin
        rdata_reg <= ext_data;
      end
    end
  end

endmodule
